// File: rtl/apb_ram128x8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_ram128x8_ctrl_pkg
//  Brief    : Shared sizes and FSM state encoding for the APB 128x8 RAM
//             controller and its clear sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package apb_ram128x8_ctrl_pkg;

    localparam int RAM_DEPTH   = 128;
    localparam int RAM_AWIDTH  = 7;
    localparam int DATA_WIDTH  = 8;
    localparam int PADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/apb_ram128x8_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_ram128x8_ctrl_if
//  Brief    : APB3 bus bundle between the CoreABC master mux and the RAM
//             controller.
//  Revision : 1.0  initial release
// ============================================================================
interface apb_ram128x8_ctrl_if;
    import apb_ram128x8_ctrl_pkg::*;

    logic                   PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [PADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0]  PWDATA;
    logic [DATA_WIDTH-1:0]  PRDATA;
    logic                   PREADY;
    logic                   PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface
`default_nettype wire

// File: rtl/apb_ram128x8_ctrl_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ram_clear_seq
//  Brief    : Post-reset zero fill of all RAM words, one word per cycle.
//             Only instantiated when APB_RAM_CLEAR_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module ram_clear_seq
    import apb_ram128x8_ctrl_pkg::*;
(
    input  logic                  PCLK,
    input  logic                  PRESETN,
    output logic                  o_busy,
    output logic                  o_last,
    output logic                  o_wen,
    output logic [RAM_AWIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wd
);

    logic [RAM_AWIDTH-1:0] r_cnt;
    logic                  r_busy;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Write strobe held off while reset is asserted so no stray write lands.
    assign o_wen   = r_busy & PRESETN;
    assign o_last  = r_busy & (&r_cnt);
    assign o_busy  = r_busy;
    assign o_waddr = r_cnt;
    assign o_wd    = '0;

endmodule
`default_nettype wire

// File: rtl/apb_ram128x8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : apb_ram128x8_ctrl
//  Brief    : APB3 completer for the CoreABC 128x8 scratch RAM; one wait state
//             on reads, PSLVERR on out-of-range addresses.
//             Optional post-reset clear: define APB_RAM_CLEAR_EN.
//  Revision : 1.0  initial release
// ============================================================================
module apb_ram128x8_ctrl
    import apb_ram128x8_ctrl_pkg::*;
(
    input  logic                  PCLK,
    input  logic                  PRESETN,
    apb_ram128x8_ctrl_if.slave    apb,
    output logic [DATA_WIDTH-1:0] RAM_WD,
    output logic [RAM_AWIDTH-1:0] RAM_WADDR,
    output logic                  RAM_WEN,
    output logic [RAM_AWIDTH-1:0] RAM_RADDR,
    input  logic [DATA_WIDTH-1:0] RAM_RD,
    output logic                  INIT_BUSY
);

    state_t r_state;
    state_t w_next;
    logic   w_access;
    logic   w_in_range;

`ifdef APB_RAM_CLEAR_EN
    localparam state_t c_rst_state = ST_INIT;

    logic                  w_clr_last;
    logic                  w_clr_wen;
    logic [RAM_AWIDTH-1:0] w_clr_waddr;
    logic [DATA_WIDTH-1:0] w_clr_wd;

    ram_clear_seq u_clear_seq (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .o_busy  (INIT_BUSY),
        .o_last  (w_clr_last),
        .o_wen   (w_clr_wen),
        .o_waddr (w_clr_waddr),
        .o_wd    (w_clr_wd)
    );
`else
    localparam state_t c_rst_state = ST_IDLE;

    assign INIT_BUSY = 1'b0;
`endif

    assign w_access   = apb.PSEL & apb.PENABLE;
    assign w_in_range = (apb.PADDR[PADDR_WIDTH-1:RAM_AWIDTH] == '0);

    // The registered RAM read captures on every edge, so the address simply follows PADDR.
    assign RAM_RADDR = apb.PADDR[RAM_AWIDTH-1:0];

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state <= c_rst_state;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        apb.PREADY  = 1'b1;
        apb.PSLVERR = 1'b0;
        apb.PRDATA  = '0;
        RAM_WEN     = 1'b0;
        RAM_WADDR   = apb.PADDR[RAM_AWIDTH-1:0];
        RAM_WD      = apb.PWDATA;

        case (r_state)
`ifdef APB_RAM_CLEAR_EN
            ST_INIT: begin
                apb.PREADY = 1'b0;
                RAM_WEN    = w_clr_wen;
                RAM_WADDR  = w_clr_waddr;
                RAM_WD     = w_clr_wd;
                if (w_clr_last) begin
                    w_next = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                if (w_access) begin
                    if (!w_in_range) begin
                        apb.PSLVERR = 1'b1;
                    end else if (apb.PWRITE) begin
                        RAM_WEN = 1'b1;
                    end else begin
                        apb.PREADY = 1'b0;
                        w_next     = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                // Completes even if the master dropped PSEL, so the FSM cannot lock up.
                apb.PRDATA = RAM_RD;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = c_rst_state;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_ram128x8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_ram128x8_ctrl
//  Brief    : Self-checking bench: directed and random APB transfers checked
//             against an array model of the RAM contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_ram128x8_ctrl;
    import apb_ram128x8_ctrl_pkg::*;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic [7:0] RAM_WD;
    logic [6:0] RAM_WADDR;
    logic       RAM_WEN;
    logic [6:0] RAM_RADDR;
    logic [7:0] RAM_RD;
    logic       INIT_BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 PCLK = ~PCLK;

    apb_ram128x8_ctrl_if bus ();

    apb_ram128x8_ctrl dut (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .apb       (bus.slave),
        .RAM_WD    (RAM_WD),
        .RAM_WADDR (RAM_WADDR),
        .RAM_WEN   (RAM_WEN),
        .RAM_RADDR (RAM_RADDR),
        .RAM_RD    (RAM_RD),
        .INIT_BUSY (INIT_BUSY)
    );

    // Behaviour of the RAM macro: write and registered read on the same clock.
    logic [7:0] ram_mem [128];
    always @(posedge PCLK) begin
        if (RAM_WEN) ram_mem[RAM_WADDR] <= RAM_WD;
        RAM_RD <= ram_mem[RAM_RADDR];
    end

    // Functional write monitor (clear-sequence writes excluded).
    int         wen_total = 0;
    logic [6:0] mon_waddr;
    logic [7:0] mon_wd;
    always @(negedge PCLK) begin
        if (PRESETN && RAM_WEN && !INIT_BUSY) begin
            wen_total = wen_total + 1;
            mon_waddr = RAM_WADDR;
            mon_wd    = RAM_WD;
        end
    end

    // Expected RAM contents; a word is only known once written (or cleared).
    logic [7:0] ref_mem   [128];
    bit         ref_valid [128];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data, input bit chk_lat);
        int         n;
        int         w0;
        logic [7:0] rd;
        logic       err;
        bit         in_rng;
        n      = 0;
        w0     = wen_total;
        in_rng = (addr < 8'd128);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = data;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        while (1) begin
            @(negedge PCLK);
            n++;
            if (bus.PREADY || n >= 400) break;
            @(posedge PCLK); #1;
        end
        rd  = bus.PRDATA;
        err = bus.PSLVERR;
        @(posedge PCLK); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;

        check_eq("timeout", 32'(n < 400), 32'd1);
        check_eq("pslverr", 32'(err), 32'(!in_rng));
        if (chk_lat)
            check_eq("cycles", 32'(n + 1), (in_rng && !wr) ? 32'd3 : 32'd2);
        if (in_rng && wr) begin
            check_eq("wen_pulses", 32'(wen_total - w0), 32'd1);
            check_eq("waddr", 32'(mon_waddr), 32'(addr[6:0]));
            check_eq("wdata", 32'(mon_wd), 32'(data));
            ref_mem[addr[6:0]]   = data;
            ref_valid[addr[6:0]] = 1'b1;
        end else begin
            check_eq("no_wen", 32'(wen_total - w0), 32'd0);
        end
        if (!in_rng || wr)
            check_eq("prdata_zero", 32'(rd), 32'd0);
        else if (ref_valid[addr[6:0]])
            check_eq("prdata", 32'(rd), 32'(ref_mem[addr[6:0]]));
    endtask

    task automatic do_reset(input bit wait_init);
        int cnt;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        PRESETN     = 1'b0;
        #1;
        check_eq("rst_prdata", 32'(bus.PRDATA), 32'd0);
        check_eq("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
        check_eq("rst_wen", 32'(RAM_WEN), 32'd0);
`ifdef APB_RAM_CLEAR_EN
        check_eq("rst_pready", 32'(bus.PREADY), 32'd0);
        check_eq("rst_init_busy", 32'(INIT_BUSY), 32'd1);
`else
        check_eq("rst_pready", 32'(bus.PREADY), 32'd1);
        check_eq("rst_init_busy", 32'(INIT_BUSY), 32'd0);
`endif
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETN = 1'b1;
`ifdef APB_RAM_CLEAR_EN
        for (int i = 0; i < 128; i++) begin
            ref_mem[i]   = 8'h00;
            ref_valid[i] = 1'b1;
        end
        if (wait_init) begin
            cnt = 0;
            while (INIT_BUSY && cnt < 300) begin
                cnt++;
                @(negedge PCLK);
            end
            check_eq("init_cycles", 32'(cnt), 32'd128);
        end
`else
        if (wait_init) begin
            repeat (5) begin
                @(negedge PCLK);
                check_eq("init_busy_low", 32'(INIT_BUSY), 32'd0);
            end
        end
`endif
        @(posedge PCLK); #1;
    endtask

    initial begin
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        for (int i = 0; i < 128; i++) ref_valid[i] = 1'b0;

        do_reset(1'b1);

        // Write then read back
        xfer(1'b1, 8'h05, 8'hA5, 1'b1);
        xfer(1'b0, 8'h05, 8'h00, 1'b1);
        check_eq("rd_a5_model", 32'(ref_mem[5]), 32'hA5);

        // Back-to-back at both ends of the address range
        xfer(1'b1, 8'h00, 8'h3C, 1'b1);
        xfer(1'b1, 8'h7F, 8'hC3, 1'b1);
        xfer(1'b0, 8'h7F, 8'h00, 1'b1);
        xfer(1'b0, 8'h00, 8'h00, 1'b1);

        // Out-of-range, then confirm address 0 untouched
        xfer(1'b1, 8'h80, 8'h11, 1'b1);
        xfer(1'b0, 8'h80, 8'h00, 1'b1);
        xfer(1'b0, 8'h00, 8'h00, 1'b1);

        // Reset while in RD_WAIT
        xfer(1'b1, 8'h12, 8'h5A, 1'b1);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 8'h12;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        check_eq("rdwait_pready", 32'(bus.PREADY), 32'd1);
        check_eq("rdwait_prdata", 32'(bus.PRDATA), 32'h5A);
        PRESETN     = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        #1;
`ifdef APB_RAM_CLEAR_EN
        check_eq("midrst_pready", 32'(bus.PREADY), 32'd0);
`else
        check_eq("midrst_pready", 32'(bus.PREADY), 32'd1);
`endif
        check_eq("midrst_prdata", 32'(bus.PRDATA), 32'd0);
        check_eq("midrst_wen", 32'(RAM_WEN), 32'd0);
        do_reset(1'b1);
        xfer(1'b0, 8'h12, 8'h00, 1'b1);

`ifdef APB_RAM_CLEAR_EN
        // Read issued mid-clear stalls until INIT ends and sees the cleared word
        xfer(1'b1, 8'h7F, 8'hFF, 1'b1);
        do_reset(1'b0);
        repeat (10) @(posedge PCLK);
        #1;
        check_eq("clr_busy_mid", 32'(INIT_BUSY), 32'd1);
        xfer(1'b0, 8'h7F, 8'h00, 1'b0);
        check_eq("clr_busy_done", 32'(INIT_BUSY), 32'd0);
        check_eq("clr_model", 32'(ref_mem[127]), 32'd0);
`endif

        // Random traffic, mostly in a small window to get read-after-write hits
        for (int k = 0; k < 80; k++) begin
            logic [7:0] a;
            logic [7:0] d;
            bit         w;
            if ($urandom_range(0, 7) == 0)
                a = 8'h80 | 8'($urandom_range(0, 127));
            else
                a = 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            w = bit'($urandom_range(0, 1));
            xfer(w, a, d, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge PCLK); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_ram128x8_ctrl.md
# apb_ram128x8_ctrl

APB3 completer that owns the CoreABC 128x8 scratch RAM's write and read ports. It turns processor APB transfers into RAM write strobes and synchronous read cycles. It inserts the wait state the registered RAM read needs, and flags out-of-range addresses. It sits between the CoreABC APB master mux and the RAM macro; the integrator ties the RAM's WCLK and RCLK to PCLK.

## Interface
- RAM_DEPTH, 128: number of RAM words; fixed by the macro.
- RAM_AWIDTH, 7: RAM address width, log2(RAM_DEPTH).
- PADDR_WIDTH, 8: APB address width; PADDR >= RAM_DEPTH is out of range.
- PCLK  in  1  block clock; the RAM clocks are tied to it.
- PRESETN  in  1  asynchronous, active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  PADDR_WIDTH  byte address.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data; 0 when not completing a read.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  out-of-range error; valid only when PREADY is high.
- RAM_WD  out  8  RAM write data.
- RAM_WADDR  out  RAM_AWIDTH  RAM write address.
- RAM_WEN  out  1  RAM write enable, active high.
- RAM_RADDR  out  RAM_AWIDTH  RAM read address; the RAM samples it every PCLK edge.
- RAM_RD  in  8  RAM registered read data.
- INIT_BUSY  out  1  clear sequence running; tied 0 without the macro.

## Operation
- FSM states: INIT (macro only), IDLE, RD_WAIT.
- Reset enters IDLE, or INIT with the macro.
- Reset values: PRDATA 0, PSLVERR 0, RAM_WEN 0. PREADY is 1, or 0 in INIT. INIT_BUSY is 0, or 1 with the macro.
- Access phase means PSEL & PENABLE. An access is in range when PADDR[PADDR_WIDTH-1:RAM_AWIDTH] == 0.
- IDLE, in-range write:
  - RAM_WEN = 1 combinationally, with RAM_WADDR = PADDR[6:0] and RAM_WD = PWDATA.
  - PREADY = 1, so there is no wait state. Stay in IDLE.
- IDLE, in-range read:
  - PREADY = 0. Go to RD_WAIT.
  - RAM_RADDR = PADDR[6:0] at all times outside INIT, so the RAM captures the word at this edge.
- RD_WAIT:
  - PRDATA = RAM_RD and PREADY = 1. Go to IDLE unconditionally, including when PSEL has dropped (a protocol violation; no lock-up).
- IDLE, out-of-range access of either direction:
  - PREADY = 1 and PSLVERR = 1. No RAM_WEN. PRDATA = 0.
- Outside the access phase: PREADY = 1, PSLVERR = 0, RAM_WEN = 0.
- Read after write to the same address, in consecutive transfers: the read returns the new data. The write commits at the access-cycle edge, and the read samples at a later edge.
- Reset asserted mid-transfer: the FSM returns to its reset state immediately and RAM_WEN drops. RAM contents are not altered except by the clear sequence.

## Timing
- Write transfer: 2 PCLK (setup + access). RAM_WEN is high for exactly the access cycle.
- Read transfer: 3 PCLK (setup, access with PREADY=0, access with PREADY=1 and data).
- Error transfer: 2 PCLK.
- Back-to-back transfers are supported with no idle cycle between them.
- All outputs are combinational from state and APB inputs. No output depends on RAM_RD except PRDATA in RD_WAIT.

## Configuration
- APB_RAM_CLEAR_EN defined:
  - After PRESETN deasserts, INIT walks a 7-bit counter from 0 to 127.
  - Each cycle drives RAM_WEN = 1, RAM_WD = 0, RAM_WADDR = counter, with INIT_BUSY = 1.
  - Exits to IDLE after writing address 127, so INIT lasts 128 cycles.
  - Any APB access during INIT sees PREADY = 0 and is stalled until IDLE, then served normally.
- APB_RAM_CLEAR_EN undefined:
  - The INIT state and counter are absent and INIT_BUSY is constant 0.
  - RAM contents after reset are undefined.

## Structure
- Shared package holds:
  - state encoding constants (ST_INIT, ST_IDLE, ST_RD_WAIT);
  - RAM_DEPTH, RAM_AWIDTH, and the data width of 8.
- One sub-module: ram_clear_seq, containing the counter, INIT_BUSY, and the clear-write drive. It is instantiated only under APB_RAM_CLEAR_EN.
- Write port muxing between the sequencer and APB stays in the top level.

## Test plan
- Write 0xA5 to 0x05, then read 0x05:
  - RAM_WEN is high for one cycle with RAM_WADDR = 0x05.
  - The read shows PREADY low for one cycle, then PRDATA = 0xA5.
- Write 0x11 to 0x80, then read 0x80:
  - both transfers give PSLVERR = 1, PREADY = 1, and RAM_WEN never high;
  - the read returns PRDATA = 0;
  - a following read of 0x00 is unchanged.
- Back-to-back writes 0x3C to 0x00 and 0xC3 to 0x7F, then reads of 0x7F and 0x00 -> PRDATA 0xC3, then 0x3C.
- Reset asserted during RD_WAIT -> PREADY = 1 and PRDATA = 0 immediately; the next read of the same address completes normally.
- With APB_RAM_CLEAR_EN, after loading 0xFF at 0x7F and pulsing reset:
  - INIT_BUSY is high for exactly 128 cycles;
  - a read issued at cycle 10 stalls until INIT_BUSY falls, then returns 0x00.
- Without the macro: INIT_BUSY stays 0, and the first transfer after reset completes in 2 cycles (write) or 3 cycles (read).
